examp2_operand_pair_tx: RTL and testbench
=========================================

Name: examp2_operand_pair_tx

Overview:
Transmit side of the two-operand interface consumed by the registered AND stage.
- Accepts a single stream of DATA_WIDTH words with valid/ready handshake.
- Packs consecutive words into (first, second) operand pairs and presents each pair on registered outputs with a valid/ready handshake.
- Sits between an upstream word source and any two-operand registered compute stage; provides back-pressure both ways.

Parameters:
DATA_WIDTH, 8, width of each input word and each operand output
CNT_WIDTH, 16, width of the completed-pair counter (used only with the optional feature)

Ports:
system_clock  input  1  clock, all logic on rising edge
system_rst_n  input  1  reset, asynchronous, active-low
in_data  input  DATA_WIDTH  upstream word
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept in_data this cycle (combinational from state and pair_ready)
flush  input  1  synchronous discard of a half-collected pair
first_data_out  output  DATA_WIDTH  first operand (registered)
second_data_out  output  DATA_WIDTH  second operand (registered)
pair_valid  output  1  operand pair valid (registered)
pair_ready  input  1  downstream accepts pair
half_full  output  1  first operand held, second pending (registered state decode)
pair_count  output  CNT_WIDTH  completed pairs (optional feature)

Behaviour:
- Reset (async, system_rst_n=0):
  - State EMPTY.
  - first_data_out=0, second_data_out=0, pair_valid=0, half_full=0, pair_count=0.
  - in_ready=0 while reset is asserted.
- Handshake rules:
  - Word accepted when in_valid & in_ready at a clock edge.
  - Pair transferred when pair_valid & pair_ready at a clock edge.
  - in_data is ignored when not accepted.
- FSM states: EMPTY, HALF, FULL (2-bit encoding).
  - EMPTY:
    - in_ready=1.
    - On accept: first_data_out<=in_data; go to HALF.
  - HALF:
    - in_ready=1, half_full=1.
    - On accept: second_data_out<=in_data; go to FULL; pair_valid=1 from the next cycle.
  - FULL:
    - pair_valid=1, in_ready=pair_ready.
    - pair_ready & in_valid: first_data_out<=in_data; go to HALF (back-to-back; no bubble).
    - pair_ready & !in_valid: go to EMPTY.
    - !pair_ready: hold all outputs stable; in_ready=0.
- Latency:
  - Second word accepted at edge N gives pair_valid=1 after edge N.
  - Sustained throughput: 1 pair per 2 cycles.
- Data registers: update only on accept. Operand outputs are not cleared on transfer; stale values are allowed while pair_valid=0.
- flush (synchronous, sampled at the edge):
  - In EMPTY or HALF: go to EMPTY, first_data_out<=0, half_full<=0. in_ready=0 in a flush cycle; no word is accepted.
  - In FULL: the pair is not discarded. A transfer with pair_ready=1 completes normally and the state goes to EMPTY (no word is accepted). With pair_ready=0 the state stays FULL.
- Reset mid-operation: immediate return to reset values; any partial or held pair is lost.
- Unused state encoding: recover to EMPTY on the next edge.

Optional Feature:
Macro OPERAND_PAIR_COUNT_EN.
- Defined: pair_count increments by 1 on every pair transfer. It wraps from 2^CNT_WIDTH-1 to 0 and is cleared only by reset; flush has no effect on it.
- Undefined: the pair_count port still exists, is tied to 0, and no counter register is inferred.

Test Plan:
- Reset release, then in_valid=1 with words 0x3C, 0xA5 on consecutive cycles, pair_ready=1:
  - first_data_out=0x3C, second_data_out=0xA5, pair_valid=1 for exactly one cycle.
  - half_full=1 for one cycle between the two accepts.
- Back-pressure: pair 0x11/0x22 held with pair_ready=0 for 5 cycles while in_valid=1 with 0x33:
  - in_ready=0; outputs stable at 0x11/0x22.
  - When pair_ready=1 the transfer completes, 0x33 is accepted the same edge, and the state becomes HALF.
- Streaming 0x01..0x08 with in_valid and pair_ready held high:
  - Pairs (01,02), (03,04), (05,06), (07,08); pair_valid is high on alternate cycles with no lost words.
  - pair_count=4 (macro on) or 0 (macro off).
- Flush in HALF after 0x5A: state returns to EMPTY, first_data_out=0. Next words 0x0F, 0xF0 form pair 0x0F/0xF0.
- Async reset asserted in FULL mid-cycle: pair_valid, outputs and half_full are 0 immediately, without waiting for a clock edge.
- Counter wrap with CNT_WIDTH=4 and the macro on: 17 pairs sent → pair_count=1.

Source files
------------

// File: rtl/examp2_operand_pair_tx_if.sv
// rtl/examp2_operand_pair_tx_if.sv - word stream in, operand pair stream out
interface examp2_operand_pair_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] first_data_out;
    logic [DATA_WIDTH-1:0] second_data_out;
    logic                  pair_valid;
    logic                  pair_ready;

    modport master (
        input  in_data, in_valid, pair_ready,
        output in_ready, first_data_out, second_data_out, pair_valid
    );

    modport slave (
        output in_data, in_valid, pair_ready,
        input  in_ready, first_data_out, second_data_out, pair_valid
    );
endinterface

// File: rtl/examp2_operand_pair_tx.sv
// rtl/examp2_operand_pair_tx.sv - packs a word stream into operand pairs; OPERAND_PAIR_COUNT_EN adds a pair counter
module examp2_operand_pair_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       system_clock,
    input  logic                       system_rst_n,
    examp2_operand_pair_tx_if.master   bus,
    input  logic                       flush,
    output logic                       half_full,
    output logic [CNT_WIDTH-1:0]       pair_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  in_ready_c;
    logic                  pair_valid_c;
    logic                  half_full_c;
    logic                  accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] first_q;
    logic [DATA_WIDTH-1:0] second_q;

    always_ff @(posedge system_clock or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) state_nxt = HALF;
            end
            HALF: begin
                if (flush)       state_nxt = EMPTY;
                else if (accept) state_nxt = FULL;
            end
            FULL: begin
                // flush never blocks a pending transfer; it only suppresses the refill
                if (bus.pair_ready) state_nxt = accept ? HALF : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        in_ready_c   = 1'b0;
        pair_valid_c = 1'b0;
        half_full_c  = 1'b0;
        case (state)
            EMPTY: in_ready_c = !flush;
            HALF: begin
                in_ready_c  = !flush;
                half_full_c = 1'b1;
            end
            FULL: begin
                in_ready_c   = bus.pair_ready && !flush;
                pair_valid_c = 1'b1;
            end
            default: in_ready_c = 1'b0;
        endcase
        if (!system_rst_n) in_ready_c = 1'b0;
    end

    assign accept = bus.in_valid && in_ready_c;
    assign xfer   = pair_valid_c && bus.pair_ready;

    always_ff @(posedge system_clock or negedge system_rst_n) begin
        if (!system_rst_n) begin
            first_q  <= '0;
            second_q <= '0;
        end else begin
            if (accept && state != HALF) begin
                first_q <= bus.in_data;
            end else if (flush && state != FULL) begin
                first_q <= '0;
            end
            if (accept && state == HALF) begin
                second_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready        = in_ready_c;
    assign bus.pair_valid      = pair_valid_c;
    assign bus.first_data_out  = first_q;
    assign bus.second_data_out = second_q;
    assign half_full           = half_full_c;

`ifdef OPERAND_PAIR_COUNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge system_clock or negedge system_rst_n) begin
        if (!system_rst_n) begin
            count_q <= '0;
        end else if (xfer) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign pair_count = count_q;
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
    assign pair_count  = '0;
`endif

endmodule

// File: tb/tb_examp2_operand_pair_tx.sv
// tb/tb_examp2_operand_pair_tx.sv - randomized scoreboard bench for examp2_operand_pair_tx
module tb_examp2_operand_pair_tx;
    localparam int DW    = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             half_full;
    logic [CNT_W-1:0] pair_count;

    examp2_operand_pair_tx_if #(.DATA_WIDTH(DW)) bus ();

    examp2_operand_pair_tx #(.DATA_WIDTH(DW), .CNT_WIDTH(CNT_W)) dut (
        .system_clock (clk),
        .system_rst_n (rst_n),
        .bus          (bus),
        .flush        (flush),
        .half_full    (half_full),
        .pair_count   (pair_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: a word buffer holding 0, 1 or 2 words; a full buffer is the presented pair
    int           m_cnt = 0;
    logic [DW-1:0] m_first = '0;
    logic [DW-1:0] m_second = '0;
    int           m_xfers = 0;
    logic [2*DW-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !flush && (m_cnt < 2 || bus.pair_ready);
    endfunction

    task automatic model_edge();
        logic acc;
        int   cnt0;
        if (!rst_n) return;
        cnt0 = m_cnt;
        acc  = bus.in_valid && m_ready();
        if (cnt0 == 2 && bus.pair_ready) begin
            m_cnt = 0;
            m_xfers++;
        end
        if (flush && cnt0 < 2) begin
            m_cnt   = 0;
            m_first = '0;
        end
        if (acc) begin
            if (m_cnt == 0) begin
                m_first = bus.in_data;
                m_cnt   = 1;
            end else begin
                m_second = bus.in_data;
                sb.push_back({m_first, bus.in_data});
                m_cnt = 2;
            end
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic pr, input logic fl);
        @(posedge clk);
        model_edge();
        #1;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.pair_ready = pr;
        flush          = fl;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_first = '0; m_second = '0; m_xfers = 0;
        sb.delete();
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_pair_valid", bus.pair_valid, 0);
        chk("rst_first", bus.first_data_out, 0);
        chk("rst_second", bus.second_data_out, 0);
        chk("rst_half_full", half_full, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_pair_count", pair_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle handshake checks and scoreboard pop on every transfer
    initial begin
        logic [2*DW-1:0] exp_pair;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", bus.in_ready, m_ready());
                chk("pair_valid", bus.pair_valid, m_cnt == 2);
                chk("half_full", half_full, m_cnt == 1);
                chk("first_data_out", bus.first_data_out, m_first);
                chk("second_data_out", bus.second_data_out, m_second);
`ifdef OPERAND_PAIR_COUNT_EN
                chk("pair_count", pair_count, m_xfers & ((1 << CNT_W) - 1));
`else
                chk("pair_count", pair_count, 0);
`endif
                if (bus.pair_valid && bus.pair_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL pair_pop: got transfer %0h/%0h expected no pair queued",
                                 bus.first_data_out, bus.second_data_out);
                    end else begin
                        exp_pair = sb.pop_front();
                        if ({bus.first_data_out, bus.second_data_out} !== exp_pair) begin
                            errors++;
                            $display("FAIL pair_data: got %0h/%0h expected %0h/%0h",
                                     bus.first_data_out, bus.second_data_out,
                                     exp_pair[2*DW-1:DW], exp_pair[DW-1:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.pair_ready = 1'b0;
        #12;
        reset_now();

        // basic pair 3C/A5
        step(1, 8'h3C, 1, 0);
        step(1, 8'hA5, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);

        // back-pressure with 0x33 waiting
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'h33, 0, 0);
        chk("bp_first_held", bus.first_data_out, 8'h11);
        chk("bp_second_held", bus.second_data_out, 8'h22);
        step(1, 8'h33, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("bp_refill_half", half_full, 1);
        chk("bp_refill_first", bus.first_data_out, 8'h33);

        // streaming 01..08 after a clean reset
        reset_now();
        for (int w = 1; w <= 8; w++) step(1, w[DW-1:0], 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
`ifdef OPERAND_PAIR_COUNT_EN
        chk("stream_count", pair_count, 4);
`else
        chk("stream_count", pair_count, 0);
`endif

        // flush in HALF
        step(1, 8'h5A, 1, 0);
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 1, 0);
        chk("flush_first_zero", bus.first_data_out, 0);
        chk("flush_empty", half_full, 0);
        step(1, 8'h0F, 1, 0);
        step(1, 8'hF0, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 1);
        chk("flush_full_keeps", bus.pair_valid, 1);
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 1, 0);

        // async reset while FULL
        step(1, 8'h77, 0, 0);
        step(1, 8'h88, 0, 0);
        step(0, 8'h00, 0, 0);
        #2;
        reset_now();

        // counter wrap: 17 pairs
        for (int w = 0; w < 34; w++) step(1, w[DW-1:0] + 8'h40, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
`ifdef OPERAND_PAIR_COUNT_EN
        chk("wrap_count", pair_count, 1);
`else
        chk("wrap_count", pair_count, 0);
`endif

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 4) > 1),
                 ($urandom_range(0, 19) == 0));
            if (c == 1000) begin
                #2;
                reset_now();
            end
        end
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
